// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one external 4-bit ALU between two requesters.
// One operation is in flight at a time: accept, let the registered operands settle through the ALU, then hold the response.
module alu_rr_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [2:0]        rsp0_flags,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [2:0]        rsp1_flags,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zf,
  input  logic              alu_sf,
  input  logic              alu_of,
  output logic [CNT_W-1:0]  ops_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [OP_W-1:0] OP_ILLEGAL = {OP_W{1'b1}};

  logic [1:0]        rstSyncQ;
  logic              rstSyncN;

  logic [1:0]        stateQ, stateD;
  logic              ownerQ, ownerD;
  logic              lastQ, lastD;
  logic              errQ, errD;
  logic [DATA_W-1:0] aluAQ, aluAD;
  logic [DATA_W-1:0] aluBQ, aluBD;
  logic [OP_W-1:0]   aluOpQ, aluOpD;
  logic [1:0]        rspValidQ, rspValidD;
  logic [DATA_W-1:0] rspResultQ [2];
  logic [DATA_W-1:0] rspResultD [2];
  logic [2:0]        rspFlagsQ [2];
  logic [2:0]        rspFlagsD [2];
  logic [1:0]        rspErrQ, rspErrD;
  logic [CNT_W-1:0]  opsQ, opsD;

  logic              grantOne;
  logic              canAccept;
  logic              ownerRspReady;
  logic [DATA_W-1:0] selA, selB;
  logic [OP_W-1:0]   selOp;

  // Reset asserts immediately but releases two clocks later, clear of the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSyncQ <= 2'b00;
    end else begin
      rstSyncQ <= {rstSyncQ[0], 1'b1};
    end
  end

  assign rstSyncN = rstSyncQ[1];

  // lastQ=1 after reset, so a tie initially goes to requester 0.
  assign grantOne  = (req0_valid && req1_valid) ? ~lastQ : req1_valid;
  assign canAccept = (stateQ == ST_IDLE) && rstSyncN && (req0_valid || req1_valid);

  assign req0_ready = canAccept && !grantOne;
  assign req1_ready = canAccept && grantOne;

  assign selA  = grantOne ? req1_a  : req0_a;
  assign selB  = grantOne ? req1_b  : req0_b;
  assign selOp = grantOne ? req1_op : req0_op;

  assign ownerRspReady = ownerQ ? rsp1_ready : rsp0_ready;

  always_comb begin
    stateD     = stateQ;
    ownerD     = ownerQ;
    lastD      = lastQ;
    errD       = errQ;
    aluAD      = aluAQ;
    aluBD      = aluBQ;
    aluOpD     = aluOpQ;
    rspValidD  = rspValidQ;
    rspResultD = rspResultQ;
    rspFlagsD  = rspFlagsQ;
    rspErrD    = rspErrQ;
    opsD       = opsQ;

    case (stateQ)
      ST_IDLE: begin
        if (canAccept) begin
          ownerD = grantOne;
          aluAD  = selA;
          aluBD  = selB;
          // The illegal opcode still runs a harmless add; its result is discarded in EXEC.
          if (selOp == OP_ILLEGAL) begin
            aluOpD = '0;
            errD   = 1'b1;
          end else begin
            aluOpD = selOp;
            errD   = 1'b0;
          end
          stateD = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rspResultD[ownerQ] = errQ ? '0 : alu_result;
        rspFlagsD[ownerQ]  = errQ ? 3'b000 : {alu_zf, alu_sf, alu_of};
        rspErrD[ownerQ]    = errQ;
        rspValidD[ownerQ]  = 1'b1;
        stateD             = ST_RESP;
      end
      ST_RESP: begin
        if (ownerRspReady) begin
          rspValidD[ownerQ] = 1'b0;
          opsD              = opsQ + CNT_W'(1);
          lastD             = ownerQ;
          stateD            = ST_IDLE;
        end
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      stateQ        <= ST_IDLE;
      ownerQ        <= 1'b0;
      lastQ         <= 1'b1;
      errQ          <= 1'b0;
      aluAQ         <= '0;
      aluBQ         <= '0;
      aluOpQ        <= '0;
      rspValidQ     <= 2'b00;
      rspResultQ[0] <= '0;
      rspResultQ[1] <= '0;
      rspFlagsQ[0]  <= 3'b000;
      rspFlagsQ[1]  <= 3'b000;
      rspErrQ       <= 2'b00;
      opsQ          <= '0;
    end else begin
      stateQ     <= stateD;
      ownerQ     <= ownerD;
      lastQ      <= lastD;
      errQ       <= errD;
      aluAQ      <= aluAD;
      aluBQ      <= aluBD;
      aluOpQ     <= aluOpD;
      rspValidQ  <= rspValidD;
      rspResultQ <= rspResultD;
      rspFlagsQ  <= rspFlagsD;
      rspErrQ    <= rspErrD;
      opsQ       <= opsD;
    end
  end

  assign rsp0_valid  = rspValidQ[0];
  assign rsp1_valid  = rspValidQ[1];
  assign rsp0_result = rspResultQ[0];
  assign rsp1_result = rspResultQ[1];
  assign rsp0_flags  = rspFlagsQ[0];
  assign rsp1_flags  = rspFlagsQ[1];
  assign rsp0_err    = rspErrQ[0];
  assign rsp1_err    = rspErrQ[1];
  assign alu_a       = aluAQ;
  assign alu_b       = aluBQ;
  assign alu_op      = aluOpQ;
  assign ops_done    = opsQ;

endmodule
